uart_tx: RTL and testbench

//  UART transmit end of the SoC serial link; the counterpart to the oversampling receiver path.

---
 rtl/uart_tx.sv | 166 ++++++++++++++++
 tb/tb_uart_tx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte intake, LSB-first serialisation with optional parity.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // Refuse to elaborate with unsupported frame/timing parameters.
  generate
    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_err
      $error("uart_tx: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 bit_end_c;
  logic [BW-1:0]        bit_nxt_c;
  logic                 parity_c;

  assign bit_end_c = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign bit_nxt_c = bit_q + BW'(1);
  // Parity from the latched byte so busy-time changes on tx_data cannot leak in.
  assign parity_c  = (^data_q) ^ (PARITY_ODD != 0);

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic; bit boundaries come from the cycle counter wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end_c ? '0 : cnt_q + CW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tx_valid && ready_q) begin
          data_d  = tx_data;
          state_d = S_START;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      S_START: begin
        if (bit_end_c) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = data_q[0];
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              state_d = S_PARITY;
              tx_d    = parity_c;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_nxt_c;
            tx_d  = data_q[bit_nxt_c];
          end
        end
      end
      S_PARITY: begin
        if (bit_end_c) begin
          state_d = S_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end_c) begin
          if (bit_q == BW'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
            bit_d   = '0;
            tx_d    = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            ready_d = 1'b1;
          end else begin
            bit_d = bit_nxt_c;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx_ready = ready_q;
  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: 8N1, even/odd parity, back-to-back, busy noise, reset, full-rate timing.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic [2:0] v;
  logic [7:0] d [3];
  logic [2:0] tx_w, rdy_w, busy_w, done_w;
  logic       v_s;
  logic [7:0] d_s;
  logic       tx_s, rdy_s, busy_s, done_s;

  int checks = 0;
  int errors = 0;

  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_n (
    .clk(clk), .rst(rst), .tx_valid(v[0]), .tx_data(d[0]),
    .tx_ready(rdy_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));

  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_pe (
    .clk(clk), .rst(rst), .tx_valid(v[1]), .tx_data(d[1]),
    .tx_ready(rdy_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));

  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_po (
    .clk(clk), .rst(rst), .tx_valid(v[2]), .tx_data(d[2]),
    .tx_ready(rdy_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

  uart_tx #(.CLKS_PER_BIT(10416), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_slow (
    .clk(clk), .rst(rst), .tx_valid(v_s), .tx_data(d_s),
    .tx_ready(rdy_s), .tx(tx_s), .tx_busy(busy_s), .tx_done(done_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level in cycle c (1-based after accept) at 4 clocks per bit.
  function automatic logic exp_bit(input logic [7:0] b, input int c, input int par, input int odd);
    int k;
    k = (c - 1) / 4;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (par != 0 && k == 9) return (^b) ^ (odd != 0);
    return 1'b1;
  endfunction

  // Send one byte on instance sel and check the whole frame plus the done pulse.
  task automatic frame_chk(input int sel, input logic [7:0] b, input int par, input int odd,
                           input bit noise);
    int len;
    len = (10 + par) * 4;
    v[sel] = 1'b1;
    d[sel] = b;
    tick();
    v[sel] = 1'b0;
    d[sel] = ~b;
    for (int c = 1; c <= len; c++) begin
      check($sformatf("u%0d %02h tx c%0d", sel, b, c), 32'(tx_w[sel]), 32'(exp_bit(b, c, par, odd)));
      check($sformatf("u%0d rdy c%0d", sel, c), 32'(rdy_w[sel]), 32'd0);
      check($sformatf("u%0d busy c%0d", sel, c), 32'(busy_w[sel]), 32'd1);
      check($sformatf("u%0d done c%0d", sel, c), 32'(done_w[sel]), 32'd0);
      if (noise && c >= 5 && c <= 30) begin
        v[sel] = c[0];
        d[sel] = 8'h3C;
      end else begin
        v[sel] = 1'b0;
      end
      tick();
    end
    check($sformatf("u%0d done end", sel), 32'(done_w[sel]), 32'd1);
    check($sformatf("u%0d rdy end", sel), 32'(rdy_w[sel]), 32'd1);
    check($sformatf("u%0d busy end", sel), 32'(busy_w[sel]), 32'd0);
    check($sformatf("u%0d tx end", sel), 32'(tx_w[sel]), 32'd1);
    tick();
    check($sformatf("u%0d done clr", sel), 32'(done_w[sel]), 32'd0);
  endtask

  initial begin
    int dones;
    int width;
    rst = 1'b1;
    v   = 3'b000;
    v_s = 1'b0;
    d_s = 8'h00;
    for (int i = 0; i < 3; i++) d[i] = 8'h00;

    // Reset with tx_valid asserted: nothing accepted.
    v[0] = 1'b1;
    d[0] = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst tx %0d", i), 32'(tx_w[0]), 32'd1);
      check($sformatf("rst rdy %0d", i), 32'(rdy_w[0]), 32'd1);
      check($sformatf("rst busy %0d", i), 32'(busy_w[0]), 32'd0);
      check($sformatf("rst done %0d", i), 32'(done_w[0]), 32'd0);
    end
    v[0] = 1'b0;
    rst  = 1'b0;
    tick();
    check("post rst tx", 32'(tx_w[0]), 32'd1);
    check("post rst rdy", 32'(rdy_w[0]), 32'd1);

    // 8N1 frame.
    frame_chk(0, 8'hA5, 0, 0, 1'b0);
    // Even and odd parity.
    frame_chk(1, 8'h07, 1, 0, 1'b0);
    frame_chk(2, 8'h07, 1, 1, 1'b0);
    // Busy-time noise on valid/data.
    frame_chk(0, 8'hA5, 0, 0, 1'b1);

    // Back-to-back with tx_valid held high.
    dones = 0;
    v[0] = 1'b1;
    d[0] = 8'h00;
    tick();
    d[0] = 8'hFF;
    for (int c = 1; c <= 82; c++) begin
      if (c == 41 || c == 82) begin
        check($sformatf("b2b idle tx c%0d", c), 32'(tx_w[0]), 32'd1);
        check($sformatf("b2b done c%0d", c), 32'(done_w[0]), 32'd1);
        check($sformatf("b2b rdy c%0d", c), 32'(rdy_w[0]), 32'd1);
      end else if (c < 41) begin
        check($sformatf("b2b tx c%0d", c), 32'(tx_w[0]), 32'(exp_bit(8'h00, c, 0, 0)));
        check($sformatf("b2b done c%0d", c), 32'(done_w[0]), 32'd0);
      end else begin
        check($sformatf("b2b tx c%0d", c), 32'(tx_w[0]), 32'(exp_bit(8'hFF, c - 41, 0, 0)));
        check($sformatf("b2b done c%0d", c), 32'(done_w[0]), 32'd0);
      end
      if (done_w[0] === 1'b1) dones++;
      if (c == 42) v[0] = 1'b0;
      tick();
    end
    check("b2b done count", 32'(dones), 32'd2);
    check("b2b idle after", 32'(tx_w[0]), 32'd1);
    tick();

    // Reset in cycle 15 of a frame.
    v[0] = 1'b1;
    d[0] = 8'hA5;
    tick();
    v[0] = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    check("mid rst busy pre", 32'(busy_w[0]), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 16; c <= 48; c++) begin
      check($sformatf("mid rst tx c%0d", c), 32'(tx_w[0]), 32'd1);
      check($sformatf("mid rst done c%0d", c), 32'(done_w[0]), 32'd0);
      check($sformatf("mid rst rdy c%0d", c), 32'(rdy_w[0]), 32'd1);
      tick();
    end
    frame_chk(0, 8'h5A, 0, 0, 1'b0);

    // Start-bit width at full-rate divider.
    v_s = 1'b1;
    d_s = 8'hA5;
    tick();
    v_s = 1'b0;
    check("slow busy", 32'(busy_s), 32'd1);
    check("slow rdy", 32'(rdy_s), 32'd0);
    check("slow done", 32'(done_s), 32'd0);
    width = 0;
    while (tx_s === 1'b0 && width < 20000) begin
      width++;
      tick();
    end
    check("slow start width", 32'(width), 32'd10416);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
